// File: rtl/dbuf_seq_pkg.sv
// rtl/dbuf_seq_pkg.sv - shared buffer bound, default depth and FSM state encoding
package dbuf_seq_pkg;

    localparam int BOUND         = 1023;
    localparam int DEFAULT_DEPTH = 1000;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CAPTURE  = 3'd1;
    localparam logic [2:0] ST_RD_ISSUE = 3'd2;
    localparam logic [2:0] ST_RD_LOAD  = 3'd3;
    localparam logic [2:0] ST_RD_OUT   = 3'd4;

endpackage

// File: rtl/dbuf_seq_if.sv
// rtl/dbuf_seq_if.sv - capture stream, dbuf port and readout stream bundle
interface dbuf_seq_if #(
    parameter int AW = 16,
    parameter int DW = 32
) ();
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;

    logic [DW-1:0] mem_din;
    logic [AW-1:0] mem_idx;
    logic          mem_rw;
    logic [DW-1:0] mem_di;

    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;

    modport master (
        input  s_valid, s_data, mem_di, m_ready,
        output s_ready, mem_din, mem_idx, mem_rw, m_valid, m_data
    );

    modport slave (
        output s_valid, s_data, mem_di, m_ready,
        input  s_ready, mem_din, mem_idx, mem_rw, m_valid, m_data
    );
endinterface

// File: rtl/dbuf_seq.sv
// rtl/dbuf_seq.sv - captures DEPTH samples into dbuf, then streams them back in address order
module dbuf_seq
    import dbuf_seq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 16,
    parameter int DW    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    dbuf_seq_if.master bus,
    output logic       busy,
    output logic       done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [2:0]    r_state;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic          r_m_valid;
    logic [DW-1:0] r_m_data;
    logic          r_done;
    logic          w_capture;
    logic          w_accept;

    // abort/rst win over the capture handshake so no write lands in the abort cycle
    assign w_capture = (r_state == ST_CAPTURE) && !abort && !rst;
    assign w_accept  = w_capture && bus.s_valid;

    always_comb begin
        bus.s_ready = 1'b0;
        bus.mem_rw  = 1'b0;
        bus.mem_idx = '0;
        bus.mem_din = '0;
        case (r_state)
            ST_CAPTURE: begin
                bus.s_ready = w_capture;
                bus.mem_rw  = w_accept;
                bus.mem_idx = r_wptr;
                bus.mem_din = bus.s_data;
            end
            ST_RD_ISSUE, ST_RD_LOAD, ST_RD_OUT: begin
                bus.mem_idx = r_rptr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state   <= ST_IDLE;
                r_wptr    <= '0;
                r_rptr    <= '0;
                r_m_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state <= ST_CAPTURE;
                            r_wptr  <= '0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (w_accept) begin
                            if (r_wptr == LAST_IDX) begin
                                r_state <= ST_RD_ISSUE;
                                r_rptr  <= '0;
                            end else begin
                                r_wptr <= r_wptr + AW'(1);
                            end
                        end
                    end
                    ST_RD_ISSUE: r_state <= ST_RD_LOAD;
                    // dbuf registers its read, so mem_di is valid one cycle after issue
                    ST_RD_LOAD: begin
                        r_m_data  <= bus.mem_di;
                        r_m_valid <= 1'b1;
                        r_state   <= ST_RD_OUT;
                    end
                    ST_RD_OUT: begin
                        if (bus.m_ready) begin
                            r_m_valid <= 1'b0;
                            if (r_rptr == LAST_IDX) begin
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_rptr  <= r_rptr + AW'(1);
                                r_state <= ST_RD_ISSUE;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;

endmodule
